// File: rtl/scalar_multiplier_arbiter.sv
// Round-robin arbiter that shares one pipelined 64-bit multiplier between two requesters.
// Define MUL_ARB_PERF_CNT_EN to add the grant and conflict performance counters.
module scalar_multiplier_arbiter #(
    parameter int TAG_W   = 5,
    parameter int LATENCY = 2
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [2:0]         req0_funct3_i,
    input  logic               req0_mul32_i,
    input  logic [63:0]        req0_rs1_i,
    input  logic [63:0]        req0_rs2_i,
    input  logic [TAG_W-1:0]   req0_tag_i,
    input  logic               flush0_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [2:0]         req1_funct3_i,
    input  logic               req1_mul32_i,
    input  logic [63:0]        req1_rs1_i,
    input  logic [63:0]        req1_rs2_i,
    input  logic [TAG_W-1:0]   req1_tag_i,
    input  logic               flush1_i,
    output logic               resp0_valid_o,
    output logic [63:0]        resp0_rd_o,
    output logic [TAG_W-1:0]   resp0_tag_o,
    output logic               resp1_valid_o,
    output logic [63:0]        resp1_rd_o,
    output logic [TAG_W-1:0]   resp1_tag_o,
    output logic [127:0]       resp1_rd_complete_o,
    output logic               mul_request_o,
    output logic [2:0]         mul_funct3_o,
    output logic               mul_32b_o,
    output logic [63:0]        mul_rs1_o,
    output logic [63:0]        mul_rs2_o,
    input  logic [63:0]        mul_rd_i,
    input  logic [127:0]       mul_rd_complete_i,
`ifdef MUL_ARB_PERF_CNT_EN
    input  logic               perf_clear_i,
    output logic [31:0]        perf_grant0_o,
    output logic [31:0]        perf_grant1_o,
    output logic [31:0]        perf_conflict_o,
`endif
    output logic               busy_o
);

    logic             r_ptr;
    logic             r_stValid [LATENCY];
    logic             r_stPort  [LATENCY];
    logic [TAG_W-1:0] r_stTag   [LATENCY];

    logic             w_elig0;
    logic             w_elig1;
    logic             w_grant0;
    logic             w_grant1;
    logic [TAG_W-1:0] w_issueTag;
    logic             w_stLive  [LATENCY];
    logic             w_anyInflight;

    // A flushing port is simply not eligible, so it can never be granted while flushing.
    assign w_elig0  = req0_valid_i & ~flush0_i;
    assign w_elig1  = req1_valid_i & ~flush1_i;
    assign w_grant0 = w_elig0 & (~w_elig1 | ~r_ptr);
    assign w_grant1 = w_elig1 & (~w_elig0 |  r_ptr);

    assign req0_ready_o = w_grant0;
    assign req1_ready_o = w_grant1;

    always_comb begin
        mul_request_o = w_grant0 | w_grant1;
        mul_funct3_o  = '0;
        mul_32b_o     = 1'b0;
        mul_rs1_o     = '0;
        mul_rs2_o     = '0;
        w_issueTag    = '0;
        if (w_grant0) begin
            mul_funct3_o = req0_funct3_i;
            mul_32b_o    = req0_mul32_i;
            mul_rs1_o    = req0_rs1_i;
            mul_rs2_o    = req0_rs2_i;
            w_issueTag   = req0_tag_i;
        end else if (w_grant1) begin
            mul_funct3_o = req1_funct3_i;
            mul_32b_o    = req1_mul32_i;
            mul_rs1_o    = req1_rs1_i;
            mul_rs2_o    = req1_rs2_i;
            w_issueTag   = req1_tag_i;
        end
    end

    // Live means valid and not being flushed by its owner this cycle.
    always_comb begin
        w_anyInflight = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_stLive[i]   = r_stValid[i] & ~(r_stPort[i] ? flush1_i : flush0_i);
            w_anyInflight = w_anyInflight | r_stValid[i];
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ptr <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                r_stValid[i] <= 1'b0;
                r_stPort[i]  <= 1'b0;
                r_stTag[i]   <= '0;
            end
        end else begin
            if (w_grant0 | w_grant1) begin
                r_ptr <= w_grant0;
            end
            r_stValid[0] <= w_grant0 | w_grant1;
            r_stPort[0]  <= w_grant1;
            r_stTag[0]   <= w_issueTag;
            for (int i = 1; i < LATENCY; i++) begin
                r_stValid[i] <= w_stLive[i-1];
                r_stPort[i]  <= r_stPort[i-1];
                r_stTag[i]   <= r_stTag[i-1];
            end
        end
    end

    always_comb begin
        resp0_valid_o       = 1'b0;
        resp0_rd_o          = '0;
        resp0_tag_o         = '0;
        resp1_valid_o       = 1'b0;
        resp1_rd_o          = '0;
        resp1_tag_o         = '0;
        resp1_rd_complete_o = '0;
        if (w_stLive[LATENCY-1]) begin
            if (r_stPort[LATENCY-1]) begin
                resp1_valid_o       = 1'b1;
                resp1_rd_o          = mul_rd_i;
                resp1_tag_o         = r_stTag[LATENCY-1];
                resp1_rd_complete_o = mul_rd_complete_i;
            end else begin
                resp0_valid_o = 1'b1;
                resp0_rd_o    = mul_rd_i;
                resp0_tag_o   = r_stTag[LATENCY-1];
            end
        end
    end

    assign busy_o = req0_valid_i | req1_valid_i | w_anyInflight;

`ifdef MUL_ARB_PERF_CNT_EN
    logic [31:0] r_perfGrant0;
    logic [31:0] r_perfGrant1;
    logic [31:0] r_perfConflict;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_perfGrant0   <= '0;
            r_perfGrant1   <= '0;
            r_perfConflict <= '0;
        end else if (perf_clear_i) begin
            r_perfGrant0   <= '0;
            r_perfGrant1   <= '0;
            r_perfConflict <= '0;
        end else begin
            if (w_grant0)           r_perfGrant0   <= r_perfGrant0 + 32'd1;
            if (w_grant1)           r_perfGrant1   <= r_perfGrant1 + 32'd1;
            if (w_elig0 & w_elig1)  r_perfConflict <= r_perfConflict + 32'd1;
        end
    end

    assign perf_grant0_o   = r_perfGrant0;
    assign perf_grant1_o   = r_perfGrant1;
    assign perf_conflict_o = r_perfConflict;
`endif

endmodule

// File: doc/scalar_multiplier_arbiter.md
Name: scalar_multiplier_arbiter

Overview:
- Shares one pipelined 64-bit scalar multiplier (fixed latency, one issue per cycle, no backpressure) between two requesters: port 0 = scalar integer pipe, port 1 = vector unit scalar-operand path.
- Round-robin arbitration with a valid/ready handshake per port.
- Tracks requester ID and tag through the multiplier pipeline, routes each result back to its owner, and supports per-port flush of in-flight operations.

Parameters:
- TAG_W, 5, width of the requester tag carried alongside each operation.
- LATENCY, 2, cycles from multiplier issue to result visibility; must match the multiplier; legal range 1..4.

Ports:
- clock_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- reqN_valid_i  in  1  port N request valid (N=0,1)
- reqN_ready_o  out  1  port N accepted this cycle
- reqN_funct3_i  in  3  mul/mulh/mulhu/mulhsu encoding
- reqN_mul32_i  in  1  32-bit multiply select
- reqN_rs1_i, reqN_rs2_i  in  64  multiplicand, multiplier
- reqN_tag_i  in  TAG_W  requester tag
- flushN_i  in  1  kill all in-flight port N ops; block port N grant this cycle
- respN_valid_o  out  1  result valid for port N (single-cycle pulse, no backpressure)
- respN_rd_o  out  64  low/high product half
- respN_tag_o  out  TAG_W  tag of returning op
- resp1_rd_complete_o  out  128  full product (port 1 only)
- mul_request_o  out  1  issue strobe to multiplier
- mul_funct3_o  out  3  forwarded funct3
- mul_32b_o  out  1  forwarded 32-bit select
- mul_rs1_o, mul_rs2_o  out  64  forwarded operands
- mul_rd_i  in  64  multiplier result
- mul_rd_complete_i  in  128  multiplier full product
- busy_o  out  1  any request valid or any op in flight

Behaviour:
- Reset (async, reset_ni=0): round-robin pointer = 0; all in-flight stages invalid; all resp*_valid_o = 0; resp data/tag = 0; busy_o = 0. reset_ni and the multiplier reset are the same net; reset mid-operation discards all in-flight ops with no response.
- Arbitration (combinational):
  - eligibleN = reqN_valid_i & ~flushN_i.
  - Both eligible: grant the port at the pointer.
  - One eligible: grant that port.
  - Grant issues mul_request_o = 1 with the granted port's funct3/mul32/rs1/rs2; reqN_ready_o = grantN.
  - No grant: mul_request_o = 0 and operand outputs are 0.
  - reqN_ready_o may depend on reqN_valid_i. Requesters must not make valid depend on ready, and must hold payload stable while valid & ~ready.
- Pointer update (registered): on any grant, the pointer is set to the non-granted port. With no grant, the pointer holds.
- In-flight tracking: a LATENCY-deep shift register of {valid, port, tag}. Stage 0 loads {grant, granted port, tag} each cycle; stages shift every cycle.
- Flush:
  - flushN_i clears valid in every stage whose port == N in the same cycle, including the entry being loaded.
  - A flushed op still executes in the multiplier, but its result is dropped.
  - Flush on one port never affects the other port's ops.
- Response:
  - When the last stage is valid, resp{port}_valid_o = 1 and respN_tag_o = stage tag.
  - respN_rd_o = mul_rd_i; resp1_rd_complete_o = mul_rd_complete_i.
  - Response outputs are combinational from the last stage and multiplier outputs. Outputs of the non-responding port are 0.
- Throughput: one issue per cycle sustained. Back-to-back ops from the same port are allowed; results return in issue order.
- Simultaneous events:
  - A response and a new grant to the same port in one cycle are both legal.
  - Flush and valid on the same port in one cycle: no grant to that port; the other port may be granted.
- busy_o = req0_valid_i | req1_valid_i | OR of stage valids.

Optional Feature:
- Macro MUL_ARB_PERF_CNT_EN.
- When defined, adds these ports:
  - perf_clear_i  in  1  synchronous clear
  - perf_grant0_o  out  32
  - perf_grant1_o  out  32
  - perf_conflict_o  out  32
- Counter behaviour:
  - Counters increment on grant to port 0, grant to port 1, and cycles with both ports eligible, respectively.
  - Counters wrap modulo 2^32 and reset to 0.
  - perf_clear_i has priority over increment.
- When undefined: no ports, no counter logic; arbitration behaviour identical.

Test Plan:
- Reset, single op: port 0 issues mul, rs1=7, rs2=-3, tag=4 -> mul_request_o=1 in cycle T; resp0_valid_o=1 in T+2 with resp0_rd_o=64'hFFFF_FFFF_FFFF_FFEB, tag=4; resp1_valid_o=0 throughout.
- Contention: both ports valid continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; responses alternate with matching tags, 2 cycles behind each grant.
- Port 1 mulhu, rs1=rs2=64'hFFFF_FFFF_FFFF_FFFF -> resp1_rd_o=64'hFFFF_FFFF_FFFF_FFFE and resp1_rd_complete_o=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Flush: port 0 issues tags 1,2 on consecutive cycles and port 1 issues tag 9; flush0_i pulsed the cycle after tag 2 issues -> no resp0_valid_o for tags 1,2; resp1 tag 9 still returns.
- Flush with valid on the same port: flush0_i=1 with req0_valid_i=1 and req1_valid_i=1 -> req1_ready_o=1, req0_ready_o=0, pointer set to port 0.
- Reset mid-operation: assert reset_ni=0 one cycle after issue -> no response ever; busy_o=0 immediately; perf counters (when compiled in) read 0.
